// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : State encoding and HD44780 command bytes shared by the LCD
//               bus arbiter and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    localparam logic [3:0] ST_PWRUP    = 4'd0;
    localparam logic [3:0] ST_INIT_FS  = 4'd1;
    localparam logic [3:0] ST_INIT_DO  = 4'd2;
    localparam logic [3:0] ST_INIT_EM  = 4'd3;
    localparam logic [3:0] ST_INIT_CLR = 4'd4;
    localparam logic [3:0] ST_IDLE     = 4'd5;
    localparam logic [3:0] ST_ADDR     = 4'd6;
    localparam logic [3:0] ST_DATA     = 4'd7;
    localparam logic [3:0] ST_CMD      = 4'd8;

    localparam logic [7:0] CMD_FUNC_SET  = 8'h3C;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] ROW2_OFS      = 8'h40;

    function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
        return CMD_SET_DDRAM | (row ? ROW2_OFS : 8'h00) | {4'h0, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin pick: first asserted request after the pointer,
//               pointer moves to the winner when LOAD is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                      CLK,
    input  logic                      RESETN,
    input  logic [NREQ-1:0]           REQ,
    input  logic                      LOAD,
    output logic                      VALID,
    output logic [$clog2(NREQ)-1:0]   IDX
);

    localparam int IDX_W = $clog2(NREQ);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_cand;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDX_W'((int'(r_ptr) + i) % NREQ);
            if (!w_found && REQ[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            r_ptr <= '0;
        end else if (LOAD && w_found) begin
            r_ptr <= w_idx;
        end
    end

    assign VALID = w_found;
    assign IDX   = w_idx;

endmodule
`default_nettype wire

// File: rtl/lcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_arbiter
// Description : Owns the character LCD bus, runs power-up init, then serves
//               character writes and raw commands from NREQ requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_arbiter #(
    parameter int NREQ        = 2,
    parameter int POWERUP_CYC = 70,
    parameter int OP_CYC      = 30,
    parameter int CLEAR_CYC   = 200,
    parameter int E_CYC       = 4
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     REQ_RS,
    input  logic [NREQ-1:0]     REQ_ROW,
    input  logic [4*NREQ-1:0]   REQ_COL,
    input  logic [8*NREQ-1:0]   REQ_DATA,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     DONE,
    output logic                BUSY,
    output logic                INIT_DONE,
    output logic                LCD_E,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic [7:0]          LCD_DATA
);
    import lcd_pkg::*;

    localparam int IDX_W   = $clog2(NREQ);
    localparam int CNT_MAX = (POWERUP_CYC > CLEAR_CYC) ?
                             ((POWERUP_CYC > OP_CYC) ? POWERUP_CYC : OP_CYC) :
                             ((CLEAR_CYC > OP_CYC) ? CLEAR_CYC : OP_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [3:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lat_row;
    logic [3:0]       r_lat_col;
    logic [7:0]       r_lat_data;
    logic [IDX_W-1:0] r_win;
    logic             r_init_done;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic             r_busy;
    logic             r_lcd_e;
    logic             r_lcd_rs;
    logic             r_lcd_rw;
    logic [7:0]       r_lcd_data;

    logic             w_valid;
    logic [IDX_W-1:0] w_idx;
    logic             w_grant;
    int               w_len;
    logic             w_last;
    logic [3:0]       w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_nxt_row;
    logic [3:0]       w_nxt_col;
    logic [7:0]       w_nxt_char;
    logic             w_nxt_e;
    logic             w_nxt_rs;
    logic             w_nxt_rw;
    logic [7:0]       w_nxt_data;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .CLK    (CLK),
        .RESETN (RESETN),
        .REQ    (REQ),
        .LOAD   (w_grant),
        .VALID  (w_valid),
        .IDX    (w_idx)
    );

    always_comb begin
        w_len = OP_CYC;
        if (r_state == ST_PWRUP)
            w_len = POWERUP_CYC;
        else if (r_state == ST_INIT_CLR || (r_state == ST_CMD && r_lat_data == CMD_CLEAR))
            w_len = CLEAR_CYC;
        w_last      = (r_cnt == CNT_W'(w_len - 1));
        w_grant     = 1'b0;
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + CNT_W'(1);
        if (r_state == ST_IDLE) begin
            w_nxt_cnt = '0;
            if (r_init_done && w_valid) begin
                w_grant     = 1'b1;
                w_nxt_state = REQ_RS[w_idx] ? ST_ADDR : ST_CMD;
            end
        end else if (w_last) begin
            w_nxt_cnt = '0;
            case (r_state)
                ST_PWRUP:    w_nxt_state = ST_INIT_FS;
                ST_INIT_FS:  w_nxt_state = ST_INIT_DO;
                ST_INIT_DO:  w_nxt_state = ST_INIT_EM;
                ST_INIT_EM:  w_nxt_state = ST_INIT_CLR;
                ST_ADDR:     w_nxt_state = ST_DATA;
                default:     w_nxt_state = ST_IDLE;
            endcase
        end
    end

    assign w_nxt_row  = w_grant ? REQ_ROW[w_idx]            : r_lat_row;
    assign w_nxt_col  = w_grant ? REQ_COL[4*w_idx +: 4]     : r_lat_col;
    assign w_nxt_char = w_grant ? REQ_DATA[8*w_idx +: 8]    : r_lat_data;

    // Bus pins are decoded from the next state so registered outputs line up with CNT.
    always_comb begin
        w_nxt_rs   = 1'b0;
        w_nxt_rw   = 1'b0;
        w_nxt_data = 8'h00;
        case (w_nxt_state)
            ST_INIT_FS:  w_nxt_data = CMD_FUNC_SET;
            ST_INIT_DO:  w_nxt_data = CMD_DISP_ON;
            ST_INIT_EM:  w_nxt_data = CMD_ENTRY;
            ST_INIT_CLR: w_nxt_data = CMD_CLEAR;
            ST_ADDR:     w_nxt_data = ddram_addr(w_nxt_row, w_nxt_col);
            ST_DATA: begin
                w_nxt_rs   = 1'b1;
                w_nxt_data = w_nxt_char;
            end
            ST_CMD:      w_nxt_data = w_nxt_char;
            default:     w_nxt_rw   = 1'b1;
        endcase
        w_nxt_e = !w_nxt_rw && (w_nxt_cnt >= CNT_W'(1)) && (w_nxt_cnt <= CNT_W'(E_CYC));
    end

    always_ff @(posedge CLK) begin
        if (RESETN) begin
            r_state     <= ST_PWRUP;
            r_cnt       <= '0;
            r_lat_row   <= 1'b0;
            r_lat_col   <= '0;
            r_lat_data  <= '0;
            r_win       <= '0;
            r_init_done <= 1'b0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_busy      <= 1'b1;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_rw    <= 1'b1;
            r_lcd_data  <= 8'h00;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_lat_row  <= w_nxt_row;
            r_lat_col  <= w_nxt_col;
            r_lat_data <= w_nxt_char;
            if (w_grant)
                r_win <= w_idx;
            if (r_state == ST_INIT_CLR && w_nxt_state == ST_IDLE)
                r_init_done <= 1'b1;
            r_gnt  <= w_grant ? ({{(NREQ-1){1'b0}}, 1'b1} << w_idx) : '0;
            r_done <= ((r_state == ST_DATA || r_state == ST_CMD) && w_nxt_state == ST_IDLE) ?
                      ({{(NREQ-1){1'b0}}, 1'b1} << r_win) : '0;
            r_busy     <= (w_nxt_state != ST_IDLE);
            r_lcd_e    <= w_nxt_e;
            r_lcd_rs   <= w_nxt_rs;
            r_lcd_rw   <= w_nxt_rw;
            r_lcd_data <= w_nxt_data;
        end
    end

    assign GNT       = r_gnt;
    assign DONE      = r_done;
    assign BUSY      = r_busy;
    assign INIT_DONE = r_init_done;
    assign LCD_E     = r_lcd_e;
    assign LCD_RS    = r_lcd_rs;
    assign LCD_RW    = r_lcd_rw;
    assign LCD_DATA  = r_lcd_data;

endmodule
`default_nettype wire

// File: tb/tb_lcd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lcd_arbiter
// Description : Scoreboard bench for lcd_arbiter with a timeline reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_arbiter;
    localparam int NREQ        = 2;
    localparam int POWERUP_CYC = 70;
    localparam int OP_CYC      = 30;
    localparam int CLEAR_CYC   = 200;
    localparam int E_CYC       = 4;

    logic                CLK      = 1'b0;
    logic                RESETN   = 1'b1;
    logic [NREQ-1:0]     REQ      = '0;
    logic [NREQ-1:0]     REQ_RS   = '0;
    logic [NREQ-1:0]     REQ_ROW  = '0;
    logic [4*NREQ-1:0]   REQ_COL  = '0;
    logic [8*NREQ-1:0]   REQ_DATA = '0;
    logic [NREQ-1:0]     GNT, DONE;
    logic                BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW;
    logic [7:0]          LCD_DATA;

    lcd_arbiter #(
        .NREQ(NREQ), .POWERUP_CYC(POWERUP_CYC), .OP_CYC(OP_CYC),
        .CLEAR_CYC(CLEAR_CYC), .E_CYC(E_CYC)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .REQ(REQ), .REQ_RS(REQ_RS), .REQ_ROW(REQ_ROW),
        .REQ_COL(REQ_COL), .REQ_DATA(REQ_DATA), .GNT(GNT), .DONE(DONE), .BUSY(BUSY),
        .INIT_DONE(INIT_DONE), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_DATA(LCD_DATA)
    );

    always #5 CLK = ~CLK;

    typedef struct { int c; int v; } ev_t;
    typedef struct { int start; int rs; int data; } op_t;

    ev_t gnt_q[$];
    ev_t done_q[$];
    op_t op_q[$];

    int cyc       = 0;
    int rst_edge  = -1000;
    int m_free    = 1 << 30;
    int m_init_at = 1 << 30;
    int m_ptr     = 0;
    int total     = 0;
    int bad       = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference timeline: each accepted request occupies a fixed number of cycles.
    always @(posedge CLK) begin : model
        int w;
        int len;
        int base;
        cyc++;
        if (RESETN) begin
            rst_edge = cyc;
            gnt_q.delete();
            done_q.delete();
            op_q.delete();
            m_ptr = 0;
            base  = cyc + POWERUP_CYC;
            op_q.push_back('{base,              0, 'h3C});
            op_q.push_back('{base + OP_CYC,     0, 'h0C});
            op_q.push_back('{base + 2*OP_CYC,   0, 'h06});
            op_q.push_back('{base + 3*OP_CYC,   0, 'h01});
            m_init_at = base + 3*OP_CYC + CLEAR_CYC;
            m_free    = m_init_at;
        end else if (cyc - 1 >= m_free && REQ != '0) begin
            w = -1;
            for (int i = 1; i <= NREQ; i++)
                if (w < 0 && REQ[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
            m_ptr = w;
            gnt_q.push_back('{cyc, 1 << w});
            if (REQ_RS[w]) begin
                op_q.push_back('{cyc, 0, 'h80 + int'(REQ_ROW[w]) * 'h40 + int'(REQ_COL[4*w +: 4])});
                op_q.push_back('{cyc + OP_CYC, 1, int'(REQ_DATA[8*w +: 8])});
                len = 2 * OP_CYC;
            end else begin
                len = (REQ_DATA[8*w +: 8] == 8'h01) ? CLEAR_CYC : OP_CYC;
                op_q.push_back('{cyc, 0, int'(REQ_DATA[8*w +: 8])});
            end
            m_free = cyc + len;
            done_q.push_back('{m_free, 1 << w});
        end
    end

    logic prev_e = 1'b0;
    int   e_cnt  = 0;
    op_t  cur;
    ev_t  ev;

    always @(negedge CLK) begin : monitor
        if (cyc > 0) begin
            if (cyc <= rst_edge + POWERUP_CYC - 1) begin
                chk("reset_outputs", 32'({GNT, DONE, BUSY, INIT_DONE, LCD_E, LCD_RS, LCD_RW, LCD_DATA}),
                    32'({{(2*NREQ){1'b0}}, 4'b1000, 1'b1, 8'h00}));
                e_cnt = 0;
            end else begin
                chk("init_done", 32'(INIT_DONE), 32'(cyc >= m_init_at));
                chk("busy", 32'(BUSY), 32'(cyc < m_free));
                while (gnt_q.size() > 0 && gnt_q[0].c < cyc) begin
                    chk("gnt_missing", 32'(0), 32'(gnt_q[0].v));
                    void'(gnt_q.pop_front());
                end
                if (gnt_q.size() > 0 && gnt_q[0].c == cyc) begin
                    ev = gnt_q.pop_front();
                    chk("gnt", 32'(GNT), 32'(ev.v));
                end else if (GNT != '0) chk("gnt_unexpected", 32'(GNT), 32'(0));
                while (done_q.size() > 0 && done_q[0].c < cyc) begin
                    chk("done_missing", 32'(0), 32'(done_q[0].v));
                    void'(done_q.pop_front());
                end
                if (done_q.size() > 0 && done_q[0].c == cyc) begin
                    ev = done_q.pop_front();
                    chk("done", 32'(DONE), 32'(ev.v));
                end else if (DONE != '0) chk("done_unexpected", 32'(DONE), 32'(0));
                if (cyc >= m_free && cyc >= m_init_at)
                    chk("idle_bus", 32'({LCD_E, LCD_RS, LCD_RW, LCD_DATA}), 32'({3'b001, 8'h00}));
                while (op_q.size() > 0 && op_q[0].start + 1 < cyc) begin
                    chk("op_missing", 32'(0), 32'(op_q[0].data));
                    void'(op_q.pop_front());
                end
                if (LCD_E && !prev_e) begin
                    if (op_q.size() == 0) chk("e_unexpected", 32'(1), 32'(0));
                    else begin
                        cur = op_q.pop_front();
                        chk("op_time", 32'(cyc), 32'(cur.start + 1));
                        chk("op_rs", 32'(LCD_RS), 32'(cur.rs));
                        chk("op_data", 32'(LCD_DATA), 32'(cur.data));
                        chk("op_rw", 32'(LCD_RW), 32'(0));
                    end
                end
                if (LCD_E) e_cnt++;
                if (!LCD_E && prev_e) begin
                    chk("e_width", 32'(e_cnt), 32'(E_CYC));
                    chk("op_hold", 32'({LCD_RS, LCD_DATA}), 32'({cur.rs[0], cur.data[7:0]}));
                    e_cnt = 0;
                end
            end
            prev_e = LCD_E;
        end
    end

    task automatic set_req(input int i, input bit rs, input bit row, input bit [3:0] col, input bit [7:0] d);
        REQ_RS[i]          = rs;
        REQ_ROW[i]         = row;
        REQ_COL[4*i +: 4]  = col;
        REQ_DATA[8*i +: 8] = d;
        REQ[i]             = 1'b1;
    endtask

    task automatic tick(input int raise_pct, input int wd_pct);
        bit [7:0] d;
        @(negedge CLK);
        for (int i = 0; i < NREQ; i++) begin
            if (REQ[i] && GNT[i]) REQ[i] = 1'b0;
            else if (REQ[i] && $urandom_range(99) < wd_pct) REQ[i] = 1'b0;
            else if (!REQ[i] && $urandom_range(99) < raise_pct) begin
                d = ($urandom_range(3) == 0) ? 8'h01 : 8'($urandom);
                set_req(i, 1'($urandom_range(1)), 1'($urandom_range(1)), 4'($urandom_range(15)), d);
            end
        end
    endtask

    task automatic wait_gnt(input int i, input int limit, output int at);
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge CLK);
            if (GNT[i]) begin
                at     = cyc;
                REQ[i] = 1'b0;
                break;
            end
        end
        if (at < 0) chk("gnt_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge CLK);
            if (cyc >= m_free + 2) break;
        end
    endtask

    int at;

    initial begin
        repeat (3) @(negedge CLK);
        RESETN = 1'b0;
        wait_idle(500);

        set_req(0, 1'b1, 1'b1, 4'd5, 8'h41);
        wait_gnt(0, 10, at);
        wait_idle(200);

        set_req(0, 1'b1, 1'b0, 4'd3, 8'h42);
        set_req(1, 1'b1, 1'b1, 4'd15, 8'h43);
        repeat (6 * 61 + 20) tick(100, 0);
        REQ = '0;
        wait_idle(400);

        set_req(0, 1'b0, 1'b0, 4'd0, 8'h01);
        wait_gnt(0, 10, at);
        wait_idle(400);
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h02);
        wait_gnt(1, 10, at);
        wait_idle(200);

        set_req(0, 1'b1, 1'b0, 4'd7, 8'h55);
        wait_gnt(0, 10, at);
        repeat (10) @(negedge CLK);
        RESETN = 1'b1;
        set_req(1, 1'b1, 1'b0, 4'd2, 8'h44);
        @(negedge CLK);
        RESETN = 1'b0;
        wait_gnt(1, 450, at);
        chk("gnt_after_init", 32'(at), 32'(m_init_at + 1));
        wait_idle(200);

        repeat (3000) tick(10, 2);
        REQ = '0;
        wait_idle(500);
        repeat (3) @(negedge CLK);

        chk("gnt_q_empty", 32'(gnt_q.size()), 32'(0));
        chk("done_q_empty", 32'(done_q.size()), 32'(0));
        chk("op_q_empty", 32'(op_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
